// File: rtl/seq_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_gen_pkg : mode encodings and initial/last value helpers           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seq_gen_pkg;

  localparam logic [1:0] MODE_BIN     = 2'b00;
  localparam logic [1:0] MODE_GRAY    = 2'b01;
  localparam logic [1:0] MODE_JOHNSON = 2'b10;
  localparam logic [1:0] MODE_RING    = 2'b11;

  function automatic logic [7:0] seq_mask(input int w);
    logic [8:0] t;
    t = (9'd1 << w) - 9'd1;
    return t[7:0];
  endfunction

  function automatic logic [7:0] seq_init(input logic [1:0] m, input int w);
    logic [7:0] r;
    r = (m == MODE_RING) ? 8'd1 : 8'd0;
    return r & seq_mask(w);
  endfunction

  // Binary ends at all ones; Gray, Johnson and ring all end at MSB-only.
  function automatic logic [7:0] seq_last(input logic [1:0] m, input int w);
    logic [8:0] t;
    if (m == MODE_BIN) t = (9'd1 << w) - 9'd1;
    else               t = 9'd1 << (w - 1);
    return t[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_gen_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_gen_chan : one sequence channel (binary/Gray/Johnson/ring)        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_gen_chan
  import seq_gen_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [1:0]   mode,
  output logic [W-1:0] seq_out,
  output logic         wrap
);

  logic [1:0]   mode_q, mode_d;
  logic [W-1:0] state_q, state_d;
  logic [W-1:0] seq_q, seq_d;
  logic         wrap_q, wrap_d;
  logic [W-1:0] init_val, last_val, nxt;

  assign init_val = W'(seq_init(mode, W));
  assign last_val = W'(seq_last(mode_q, W));

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    seq_d   = seq_q;
    wrap_d  = 1'b0;
    nxt     = state_q;
    if (clr || (mode != mode_q)) begin
      mode_d  = mode;
      state_d = init_val;
      seq_d   = init_val;
    end else if (en) begin
      case (mode_q)
        MODE_BIN: begin
          nxt   = state_q + 1'b1;
          seq_d = nxt;
        end
        // State keeps the binary count; output is Gray of the new count.
        MODE_GRAY: begin
          nxt   = state_q + 1'b1;
          seq_d = nxt ^ (nxt >> 1);
        end
        MODE_JOHNSON: begin
          nxt   = {state_q[W-2:0], ~state_q[W-1]};
          seq_d = nxt;
        end
        default: begin
          nxt   = {state_q[W-2:0], state_q[W-1]};
          seq_d = nxt;
        end
      endcase
      state_d = nxt;
      wrap_d  = (seq_q == last_val);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_BIN;
      state_q <= '0;
      seq_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      seq_q   <= seq_d;
      wrap_q  <= wrap_d;
    end
  end

  assign seq_out = seq_q;
  assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: rtl/multi_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_seq_gen : CH independent sequence generator channels            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module multi_seq_gen #(
  parameter int CH = 3,
  parameter int W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   clr,
  input  logic [2*CH-1:0] mode,
  output logic [CH*W-1:0] seq_out,
  output logic [CH-1:0]   wrap
);

  generate
    for (genvar i = 0; i < CH; i++) begin : g_chan
      seq_gen_chan #(
        .W (W)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en[i]),
        .clr     (clr[i]),
        .mode    (mode[2*i+1:2*i]),
        .seq_out (seq_out[W*i+W-1:W*i]),
        .wrap    (wrap[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/multi_seq_gen.md
MULTI_SEQ_GEN -- requirements
Module: multi_seq_gen

Interface
REQ-001 Parameter CH, default 3: number of independent sequence channels, 1..8.
REQ-002 Parameter W, default 3: output width per channel, 2..8.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  CH  per-channel advance enable; bit i controls channel i.
REQ-006 clr  input  CH  per-channel synchronous restart to the mode's initial value.
REQ-007 mode  input  2*CH  per-channel mode, channel i in bits [2i+1:2i]:
  - 00 binary up
  - 01 Gray
  - 10 Johnson
  - 11 one-hot ring
REQ-008 seq_out  output  CH*W  registered channel outputs; channel i in bits [W*i+W-1:W*i].
REQ-009 wrap  output  CH  registered one-cycle pulse per channel on sequence wrap.

Function
REQ-010 Each channel SHALL hold a registered mode copy mode_q, an internal state register and registered seq_out/wrap bits; there SHALL be no combinational path from inputs to outputs.
REQ-011 Per-edge priority per channel SHALL be, highest first: clr, mode change (mode != mode_q), en, hold.
REQ-012 On clr or mode change, the channel SHALL load the initial value of the current mode input, set mode_q to it, and drive wrap low.
REQ-013 Initial values SHALL be:
  - binary: 0
  - Gray: 0
  - Johnson: all zeros
  - ring: 0...01
REQ-014 Binary mode: internal count c advances c+1 mod 2^W; seq_out = c; period 2^W.
REQ-015 Gray mode: internal binary count c advances as in binary; seq_out = (c+1) XOR ((c+1)>>1), registered in the same edge; period 2^W.
REQ-016 Johnson mode: next = {s[W-2:0], ~s[W-1]}; period 2W.
REQ-017 Ring mode: rotate left by one, MSB into LSB; period W.
REQ-018 Latency: en sampled high at edge k SHALL update seq_out after edge k, one step per enabled edge; no skipped or doubled steps.
REQ-019 Wrap: wrap[i] SHALL be 1 after edge k iff that edge was an enabled advance from the mode's last value to its initial value; it SHALL otherwise be 0.
REQ-020 Last values SHALL be:
  - binary: 2^W-1
  - Gray: 1 followed by W-1 zeros
  - Johnson: 1 followed by W-1 zeros
  - ring: 1 followed by W-1 zeros
REQ-021 While en[i]=0 (and no clr/mode change), channel i SHALL hold seq_out and drive wrap[i]=0.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-023 A clr or mode change coinciding with en SHALL yield the initial value, not an advanced value.
REQ-024 Illegal internal states (e.g. ring all-zero) are unreachable; no recovery logic is required.

Reset
REQ-025 While rst=0, each channel SHALL immediately set mode_q=00, state=0, seq_out=0 and wrap=0, independent of clk.
REQ-026 After rst deasserts, a channel whose mode input is not 00 SHALL be reinitialised on the first edge via the mode-change rule.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no wrap pulse.

Structure
REQ-028 Package seq_gen_pkg SHALL hold:
  - the 2-bit mode encoding constants MODE_BIN, MODE_GRAY, MODE_JOHNSON, MODE_RING
  - functions for initial and last values parameterised by W
REQ-029 One sub-module seq_gen_chan (parameter W; ports clk, rst, en, clr, mode, seq_out, wrap) SHALL implement one channel.
REQ-030 The top SHALL instantiate CH copies of seq_gen_chan in a generate loop with no additional logic.

Verification (CH=3, W=3)
REQ-031 rst=0 then release, mode=0, en=111 for 9 edges -> channel 0 outputs 1,2,...,7,0,1; wrap[0] high only after the 8th edge.
REQ-032 mode ch1=01, en[1]=1 -> after the reinit edge seq_out=000, then 001,011,010,110,111,101,100,000; wrap on the 000 return.
REQ-033 mode ch2=10 -> 000,001,011,111,110,100,000 (period 6); mode ch2=11 -> 001,010,100,001 (period 3); wrap on each return to the initial value.
REQ-034 Binary ch0 at 5 with en and clr both high on one edge -> 0, wrap=0; en=0 for 4 edges -> value held, wrap=0.
REQ-035 rst pulsed low between clock edges while ch0=6 -> seq_out immediately 0, wrap 0; channels 1–2 with en=0 are unaffected by channel-0 activity before the reset.
REQ-036 Mode change 00->11 with en=1 on ch0 at value 3 -> next output 001 and wrap=0.
